// File: rtl/pe_operand_sequencer.sv
// Operand sequencer for the fp16 MAC processing unit.
// Ports: wr_* operand push, go/busy run control, pe_* engine handshake, res_* result.
module pe_operand_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [15:0] wr_a,
  input  logic [15:0] wr_b,
  output logic        wr_full,
  input  logic        go,
  output logic        busy,
  output logic        pe_reset,
  output logic        pe_start,
  output logic [15:0] pe_a,
  output logic [15:0] pe_b,
  input  logic [15:0] pe_p,
  input  logic        pe_ready,
  output logic        res_valid,
  output logic [15:0] res_data,
  input  logic        res_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_REL, S_OUT
  } state_e;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e      state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic [AW:0] n_q, n_d;
  logic [AW:0] idx_q, idx_d;
  logic        pe_reset_q, pe_reset_d;
  logic [15:0] pe_a_q, pe_a_d;
  logic [15:0] pe_b_q, pe_b_d;
  logic [15:0] res_q, res_d;
  logic [31:0] buf_q [DEPTH];
  logic [31:0] rd;
  logic        wr_ok;

  assign busy     = (state_q != S_IDLE);
  assign wr_full  = (count_q == FULL) || busy;
  assign wr_ok    = wr_en && !wr_full;
  assign rd       = buf_q[idx_q[AW-1:0]];
  assign pe_reset = pe_reset_q;
  assign pe_a     = pe_a_q;
  assign pe_b     = pe_b_q;
  assign res_data = res_q;

  // Storage is not reset; count defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_ok) buf_q[count_q[AW-1:0]] <= {wr_a, wr_b};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      pe_reset_q <= 1'b1;
      pe_a_q     <= '0;
      pe_b_q     <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      pe_reset_q <= pe_reset_d;
      pe_a_q     <= pe_a_d;
      pe_b_q     <= pe_b_d;
      res_q      <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_CLEAR;
      S_CLEAR: state_d = (n_q == '0) ? S_OUT : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (pe_ready) state_d = S_REL;
      S_REL: begin
        if (!pe_ready)
          state_d = (idx_q + 1'b1 < n_q) ? S_ISSUE : S_OUT;
      end
      S_OUT:   if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pe_start  = (state_q == S_WAIT);
    res_valid = (state_q == S_OUT);
  end

  always_comb begin
    count_d    = count_q;
    n_d        = n_q;
    idx_d      = idx_q;
    pe_a_d     = pe_a_q;
    pe_b_d     = pe_b_q;
    res_d      = res_q;
    pe_reset_d = (state_d == S_CLEAR);
    if (wr_ok) count_d = count_q + 1'b1;
    unique case (state_q)
      // count_d so a same-cycle write is part of the run
      S_IDLE: begin
        if (go) begin
          n_d   = count_d;
          idx_d = '0;
        end
      end
      S_CLEAR: if (n_q == '0) res_d = '0;
      S_ISSUE: begin
        pe_a_d = rd[31:16];
        pe_b_d = rd[15:0];
      end
      S_WAIT:  if (pe_ready) res_d = pe_p;
      S_REL:   if (!pe_ready) idx_d = idx_q + 1'b1;
      S_OUT:   if (res_ready) count_d = '0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_operand_sequencer.sv
// Bench for pe_operand_sequencer with a behavioural fp16 MAC unit.
// Expected results are queued at issue time; a monitor checks on handshake.
`timescale 1ns/1ps
module tb_pe_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en = 1'b0;
  logic [15:0] wr_a = '0;
  logic [15:0] wr_b = '0;
  logic        wr_full;
  logic        go = 1'b0;
  logic        busy;
  logic        pe_reset;
  logic        pe_start;
  logic [15:0] pe_a;
  logic [15:0] pe_b;
  logic [15:0] pe_p;
  logic        pe_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int starts   = 0;
  logic start_prev = 1'b0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  pe_operand_sequencer #(.DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b), .wr_full(wr_full),
    .go(go), .busy(busy),
    .pe_reset(pe_reset), .pe_start(pe_start),
    .pe_a(pe_a), .pe_b(pe_b), .pe_p(pe_p), .pe_ready(pe_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic real f2r(input logic [15:0] h);
    real v;
    int e;
    e = int'(h[14:10]);
    if (e == 0) begin
      v = real'(h[9:0]) / 16777216.0;
    end else begin
      v = 1.0 + real'(h[9:0]) / 1024.0;
      for (int i = 0; i < e - 15; i++) v = v * 2.0;
      for (int i = 0; i < 15 - e; i++) v = v / 2.0;
    end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2f(input real x);
    real v;
    int e;
    int m;
    logic s;
    logic [31:0] ev;
    logic [31:0] mv;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    v = s ? -x : x;
    e = 15;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m  = int'((v - 1.0) * 1024.0);
    ev = e;
    mv = m;
    return {s, ev[4:0], mv[9:0]};
  endfunction

  // Processing unit: fixed latency MAC, ready held until start drops.
  int   ph  = 0;
  int   lat = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_ready <= 1'b0; pe_p <= '0; ph <= 0; lat <= 0;
    end else if (pe_reset) begin
      pe_ready <= 1'b0; pe_p <= '0; ph <= 0;
    end else begin
      case (ph)
        0: if (pe_start) begin lat <= 2; ph <= 1; end
        1: begin
          if (lat == 0) begin
            pe_p     <= r2f(f2r(pe_p) + f2r(pe_a) * f2r(pe_b));
            pe_ready <= 1'b1;
            ph       <= 2;
          end else lat <= lat - 1;
        end
        default: if (!pe_start) begin pe_ready <= 1'b0; ph <= 0; end
      endcase
    end
  end

  always @(posedge clk) begin
    start_prev <= pe_start;
    if (pe_start && !start_prev) starts <= starts + 1;
  end

  always @(negedge clk) begin
    if (reset_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h expected none", res_data);
      end else begin
        check("res_data", res_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [15:0] a, input logic [15:0] b);
    wr_en = 1'b1; wr_a = a; wr_b = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!res_valid && k < 300) begin step(); k++; end
    check(name, res_valid, 1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("busy_after_accept", busy, 0);
    check("valid_after_accept", res_valid, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pe_reset"}, pe_reset, 1);
    check({tag, "_pe_start"}, pe_start, 0);
    check({tag, "_pe_a"}, pe_a, 0);
    check({tag, "_pe_b"}, pe_b, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wr_full"}, wr_full, 0);
  endtask

  int s0;

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b1; go = 1'b1; res_ready = 1'b1;
    wr_a = 16'($urandom); wr_b = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    wr_en = 1'b0; go = 1'b0; res_ready = 1'b0;
    reset_n = 1'b1;
    step();
    check("rel_pe_reset", pe_reset, 0);
    check("rel_wr_full", wr_full, 0);

    // 1*3 + 2*4 = 11
    write(16'h3C00, 16'h4200);
    write(16'h4000, 16'h4400);
    exp_q.push_back(16'h4980);
    s0 = starts;
    go = 1'b1; step(); go = 1'b0;
    check("go_busy", busy, 1);
    check("go_pe_reset", pe_reset, 1);
    step();
    check("issue_pe_reset", pe_reset, 0);
    check("issue_pe_start", pe_start, 0);
    step();
    check("wait_pe_start", pe_start, 1);
    check("wait_pe_a", pe_a, 16'h3C00);
    check("wait_pe_b", pe_b, 16'h4200);
    wait_valid("dot_valid");
    check("dot_starts", starts - s0, 2);
    repeat (5) begin
      step();
      check("hold_data", res_data, 16'h4980);
      check("hold_valid", res_valid, 1);
    end
    consume();

    // empty run
    s0 = starts;
    exp_q.push_back(16'h0000);
    go = 1'b1; step(); go = 1'b0;
    check("empty_pe_reset", pe_reset, 1);
    check("empty_valid_t1", res_valid, 0);
    step();
    check("empty_valid_t2", res_valid, 1);
    check("empty_pe_reset_t2", pe_reset, 0);
    check("empty_data", res_data, 0);
    consume();
    check("empty_starts", starts - s0, 0);

    // full buffer, extra write dropped
    for (int i = 0; i < 8; i++) write(16'h3C00, 16'h3C00);
    check("full_flag", wr_full, 1);
    write(16'h4000, 16'h4000);
    check("full_flag_extra", wr_full, 1);
    s0 = starts;
    exp_q.push_back(16'h4800);
    go = 1'b1; step(); go = 1'b0;
    wait_valid("full_valid");
    check("full_starts", starts - s0, 8);
    consume();
    check("full_cleared", wr_full, 0);

    // write with go in the same cycle, plus a go while busy
    s0 = starts;
    exp_q.push_back(16'h4400);
    wr_en = 1'b1; wr_a = 16'h4000; wr_b = 16'h4000; go = 1'b1;
    step();
    wr_en = 1'b0; go = 1'b0;
    check("b2b_busy", busy, 1);
    repeat (4) step();
    go = 1'b1; step(); go = 1'b0;
    wait_valid("b2b_valid");
    consume();
    repeat (4) step();
    check("b2b_no_requeue", busy, 0);
    check("b2b_starts", starts - s0, 1);

    // abort in WAIT_RDY
    write(16'h4200, 16'h4200);
    go = 1'b1; step(); go = 1'b0;
    begin
      int k = 0;
      while (!pe_start && k < 50) begin step(); k++; end
    end
    check("abort_in_wait", pe_start, 1);
    reset_n = 1'b0;
    #1;
    check_reset("abort");
    step();
    reset_n = 1'b1;
    step();
    check("abort_rel_pe_reset", pe_reset, 0);
    s0 = starts;
    write(16'h4000, 16'h4200);
    exp_q.push_back(16'h4600);
    go = 1'b1; step(); go = 1'b0;
    wait_valid("fresh_valid");
    check("fresh_starts", starts - s0, 1);
    consume();

    step();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
